// File: rtl/interrupt_controller_pkg.sv
// Shared types for the interrupt controller: privilege levels, cause codes,
// arbitration FSM states, reserved-bit mask and fixed priority order.
package RvTypes;

  localparam int unsigned INTR_CODE_WIDTH = 5;
  localparam int unsigned PRIV_WIDTH      = 2;
  localparam int unsigned STD_PRIO_COUNT  = 9;

  typedef logic [INTR_CODE_WIDTH-1:0] intr_code_t;

  typedef enum logic [PRIV_WIDTH-1:0] {
    Privilege_User       = 2'd0,
    Privilege_Supervisor = 2'd1,
    Privilege_Machine    = 2'd3
  } Privilege;

  typedef enum logic [INTR_CODE_WIDTH-1:0] {
    InterruptCode_UserSoftware       = 5'd0,
    InterruptCode_SupervisorSoftware = 5'd1,
    InterruptCode_MachineSoftware    = 5'd3,
    InterruptCode_UserTimer          = 5'd4,
    InterruptCode_SupervisorTimer    = 5'd5,
    InterruptCode_MachineTimer       = 5'd7,
    InterruptCode_UserExternal       = 5'd8,
    InterruptCode_SupervisorExternal = 5'd9,
    InterruptCode_MachineExternal    = 5'd11
  } InterruptCode;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } InterruptState;

  // Cause codes 2, 6, 10 and 12..15 never exist as pending sources.
  localparam logic [31:0] RESERVED_MASK = 32'h0000_F444;

  // Standard sources by rank, rank 0 being the highest priority.
  function automatic intr_code_t std_prio_code(input int rank);
    case (rank)
      0:       return InterruptCode_MachineExternal;
      1:       return InterruptCode_MachineSoftware;
      2:       return InterruptCode_MachineTimer;
      3:       return InterruptCode_SupervisorExternal;
      4:       return InterruptCode_SupervisorSoftware;
      5:       return InterruptCode_SupervisorTimer;
      6:       return InterruptCode_UserExternal;
      7:       return InterruptCode_UserSoftware;
      8:       return InterruptCode_UserTimer;
      default: return InterruptCode_UserSoftware;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Trap request handshake between the interrupt controller (master) and the
// pipeline (slave).
interface interrupt_controller_if;
  import RvTypes::*;

  logic       reqOut;
  intr_code_t codeOut;
  Privilege   targetPrivOut;
  logic       ackIn;
  logic       cancelIn;

  modport master (output reqOut, codeOut, targetPrivOut, input ackIn, cancelIn);
  modport slave  (input reqOut, codeOut, targetPrivOut, output ackIn, cancelIn);
endinterface

// File: rtl/interrupt_controller_priority_encoder.sv
// Combinational winner selection: any Machine-target source beats any
// Supervisor-target source; within a target the standard order applies,
// then local interrupts with the lowest code first.
module interrupt_priority_encoder
  import RvTypes::*;
#(
  parameter int unsigned LOCAL_COUNT = 4
) (
  input  logic [15+LOCAL_COUNT:0] i_elig_m,
  input  logic [15+LOCAL_COUNT:0] i_elig_s,
  output logic                    o_valid_c,
  output intr_code_t              o_code_c,
  output Privilege                o_target_c
);

  localparam int unsigned N = 16 + LOCAL_COUNT;

  logic [31:0]                w_m;
  logic [31:0]                w_s;
  logic [INTR_CODE_WIDTH:0]   w_pick_m;
  logic [INTR_CODE_WIDTH:0]   w_pick_s;

  assign w_m = 32'(i_elig_m);
  assign w_s = 32'(i_elig_s);

  // Scan lowest priority first so the highest-priority hit overwrites last.
  function automatic logic [INTR_CODE_WIDTH:0] pick(input logic [31:0] vec);
    logic [INTR_CODE_WIDTH:0] res;
    res = '0;
    for (int i = int'(N) - 1; i >= 16; i--) begin
      if (vec[INTR_CODE_WIDTH'(i)]) res = {1'b1, INTR_CODE_WIDTH'(i)};
    end
    for (int r = int'(STD_PRIO_COUNT) - 1; r >= 0; r--) begin
      if (vec[std_prio_code(r)]) res = {1'b1, std_prio_code(r)};
    end
    return res;
  endfunction

  // Per-target pick, then Machine over Supervisor.
  always_comb begin
    w_pick_m   = pick(w_m);
    w_pick_s   = pick(w_s);
    o_valid_c  = w_pick_m[INTR_CODE_WIDTH] | w_pick_s[INTR_CODE_WIDTH];
    o_code_c   = w_pick_m[INTR_CODE_WIDTH] ? w_pick_m[INTR_CODE_WIDTH-1:0]
                                           : w_pick_s[INTR_CODE_WIDTH-1:0];
    o_target_c = Privilege_Machine;
    if (!w_pick_m[INTR_CODE_WIDTH] && w_pick_s[INTR_CODE_WIDTH]) begin
      o_target_c = Privilege_Supervisor;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: samples interrupt lines into a registered mip view,
// keeps edge latches, checks eligibility per target privilege and presents
// one stable trap request at a time.
// Optional build macro RAFI_INTR_SYNC_EN: irqIn passes through a 2-flop
// synchronizer, adding one cycle of latency.
module interrupt_controller
  import RvTypes::*;
#(
  parameter int unsigned            LOCAL_COUNT = 4,
  parameter logic [15+LOCAL_COUNT:0] EDGE_MASK   = '0
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic [15+LOCAL_COUNT:0]   irqIn,
  input  logic [15+LOCAL_COUNT:0]   swPendingIn,
  input  logic [15+LOCAL_COUNT:0]   enableIn,
  input  logic [15+LOCAL_COUNT:0]   delegateIn,
  input  logic                      mstatusMieIn,
  input  logic                      mstatusSieIn,
  input  logic [PRIV_WIDTH-1:0]     privilegeIn,
  interrupt_controller_if.master    trap,
  output logic [15+LOCAL_COUNT:0]   pendingOut
);

  localparam int unsigned N = 16 + LOCAL_COUNT;

  logic [N-1:0]  w_irq;
  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_latch_nxt;
  logic [N-1:0]  w_pend_nxt;
  logic [N-1:0]  w_valid_mask;
  logic [N-1:0]  w_elig_m;
  logic [N-1:0]  w_elig_s;
  logic          w_m_ok;
  logic          w_s_ok;
  logic          w_ack_take;
  logic          w_enc_valid;
  intr_code_t    w_enc_code;
  Privilege      w_enc_target;

  logic [N-1:0]  r_sample;
  logic [N-1:0]  r_latch;
  logic [N-1:0]  r_pending;

  InterruptState r_state;
  InterruptState w_state_nxt;
  logic          r_req;
  logic          w_req_nxt;
  intr_code_t    r_code;
  intr_code_t    w_code_nxt;
  Privilege      r_target;
  Privilege      w_target_nxt;

`ifdef RAFI_INTR_SYNC_EN
  logic [N-1:0]  r_sync1;

  // Two-flop synchronizer; the second flop doubles as the edge-detect history.
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_sync1  <= '0;
      r_sample <= '0;
    end else begin
      r_sync1  <= irqIn;
      r_sample <= r_sync1;
    end
  end

  assign w_irq = r_sync1;
`else
  // Previous sample of the lines for edge detection.
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) r_sample <= '0;
    else        r_sample <= irqIn;
  end

  assign w_irq = irqIn;
`endif

  // An accepted (not cancelled) trap clears the edge latch of its own cause.
  assign w_ack_take   = (r_state == REQ) & trap.ackIn & ~trap.cancelIn;
  assign w_clr        = w_ack_take ? N'(32'd1 << r_code) : '0;
  assign w_rise       = w_irq & ~r_sample & EDGE_MASK;
  assign w_latch_nxt  = ((r_latch & ~w_clr) | w_rise) & EDGE_MASK;
  assign w_valid_mask = ~N'(RESERVED_MASK);
  assign w_pend_nxt   = ((EDGE_MASK & w_latch_nxt) | (~EDGE_MASK & w_irq) | swPendingIn)
                        & w_valid_mask;

  // Edge latches and the registered mip view.
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_latch   <= '0;
      r_pending <= '0;
    end else begin
      r_latch   <= w_latch_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  // Global enables for each target privilege.
  assign w_m_ok   = (privilegeIn != Privilege_Machine) | mstatusMieIn;
  assign w_s_ok   = (privilegeIn == Privilege_User)
                  | ((privilegeIn == Privilege_Supervisor) & mstatusSieIn);
  assign w_elig_m = r_pending & enableIn & ~delegateIn & {N{w_m_ok}};
  assign w_elig_s = r_pending & enableIn &  delegateIn & {N{w_s_ok}};

  interrupt_priority_encoder #(
    .LOCAL_COUNT (LOCAL_COUNT)
  ) u_prio (
    .i_elig_m   (w_elig_m),
    .i_elig_s   (w_elig_s),
    .o_valid_c  (w_enc_valid),
    .o_code_c   (w_enc_code),
    .o_target_c (w_enc_target)
  );

  // FSM state and registered request outputs.
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_code   <= '0;
      r_target <= Privilege_Machine;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_code   <= w_code_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Next state: latch the winner once, hold it until ack/cancel, then one
  // settle cycle before arbitrating again.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_code_nxt   = r_code;
    w_target_nxt = r_target;
    unique case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_nxt  = REQ;
          w_req_nxt    = 1'b1;
          w_code_nxt   = w_enc_code;
          w_target_nxt = w_enc_target;
        end
      end
      REQ: begin
        if (trap.ackIn || trap.cancelIn) begin
          w_state_nxt = HOLD;
          w_req_nxt   = 1'b0;
        end
      end
      HOLD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign trap.reqOut        = r_req;
  assign trap.codeOut       = r_code;
  assign trap.targetPrivOut = r_target;
  assign pendingOut         = r_pending;

endmodule
